// File: rtl/cmd_uart_tx_if.sv
// cmd_uart_tx_if: motor command input plus UART line and status outputs of cmd_uart_tx.
// The master side drives MOTOR_STAT; the slave side (the transmitter) drives the rest.
interface cmd_uart_tx_if;
  logic [2:0] MOTOR_STAT;
  logic       TX;
  logic       BUSY;
  logic       SENT;
  logic       PENDING;

  modport master (output MOTOR_STAT, input TX, BUSY, SENT, PENDING);
  modport slave  (input MOTOR_STAT, output TX, BUSY, SENT, PENDING);
endinterface

// File: rtl/cmd_uart_tx.sv
// cmd_uart_tx: turns changes of a 3-bit motor command into single ASCII bytes
// ('a'..'e') sent as 8N1 UART frames, with a one-deep newest-wins pending slot.
// Optional feature: define CMD_TX_PARITY_EN to add an even parity bit after bit 7.
module cmd_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic         CLK,
  input  logic         RESET,
  cmd_uart_tx_if.slave bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef CMD_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif
  localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);

  logic [2:0]  state;
  logic [2:0]  stat_q;
  logic [2:0]  last_code;
  logic [2:0]  pend_code;
  logic        primed;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  tx_byte;
  logic        tx_r;
  logic        busy_r;
  logic        sent_r;
  logic        pend_r;

  logic        in_valid;
  logic        valid_cmd;
  logic        is_zero;
  logic        new_cmd;
  logic        bit_done;
  logic        nxt_pend;
  logic [2:0]  nxt_pend_code;
  logic        launch;
  logic [2:0]  launch_code;

  // Codes 1..5 map onto 'a'..'e' (0x61..0x65).
  function automatic logic [7:0] encode(input logic [2:0] code);
    return {5'b01100, code};
  endfunction

  // Classify the registered command, resolve the pending slot and decide whether a frame starts now.
  always_comb begin
    in_valid      = (bus.MOTOR_STAT >= 3'd1) && (bus.MOTOR_STAT <= 3'd5);
    valid_cmd     = (stat_q >= 3'd1) && (stat_q <= 3'd5);
    is_zero       = (stat_q == 3'd0);
    new_cmd       = primed && valid_cmd && (stat_q != last_code);
    bit_done      = (bit_cnt == 16'd0);
    nxt_pend      = pend_r;
    nxt_pend_code = pend_code;
    if (new_cmd) begin
      nxt_pend      = 1'b1;
      nxt_pend_code = stat_q;
    end else if (primed && is_zero) begin
      nxt_pend      = 1'b0;
    end
    launch      = 1'b0;
    launch_code = stat_q;
    if (state == ST_IDLE) begin
      launch      = new_cmd;
      launch_code = stat_q;
    end else if ((state == ST_STOP) && bit_done) begin
      launch      = nxt_pend;
      launch_code = nxt_pend_code;
    end
  end

  // Track the command stream; the first sample after reset only sets the baseline so a held code is not resent.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stat_q    <= 3'd0;
      last_code <= 3'd0;
      pend_code <= 3'd0;
      pend_r    <= 1'b0;
      primed    <= 1'b0;
    end else begin
      stat_q <= bus.MOTOR_STAT;
      primed <= 1'b1;
      if (!primed) begin
        if (in_valid) last_code <= bus.MOTOR_STAT;
      end else if (new_cmd || is_zero) begin
        last_code <= stat_q;
      end
      pend_r    <= launch ? 1'b0 : nxt_pend;
      pend_code <= nxt_pend_code;
    end
  end

  // Frame sequencer: each state or bit lasts CLKS_PER_BIT cycles, a pending code chains straight from STOP into START.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= ST_IDLE;
      bit_cnt <= 16'd0;
      bit_idx <= 3'd0;
      tx_byte <= 8'd0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      sent_r  <= 1'b0;
    end else begin
      sent_r <= 1'b0;
      if (launch) begin
        state   <= ST_START;
        tx_r    <= 1'b0;
        busy_r  <= 1'b1;
        bit_cnt <= BIT_RELOAD;
        bit_idx <= 3'd0;
        tx_byte <= encode(launch_code);
        sent_r  <= (state == ST_STOP);
      end else if (state != ST_IDLE) begin
        if (!bit_done) begin
          bit_cnt <= bit_cnt - 16'd1;
        end else begin
          bit_cnt <= BIT_RELOAD;
          case (state)
            ST_START: begin
              state <= ST_DATA;
              tx_r  <= tx_byte[0];
            end
            ST_DATA: begin
              if (bit_idx == 3'd7) begin
`ifdef CMD_TX_PARITY_EN
                state <= ST_PARITY;
                tx_r  <= ^tx_byte;
`else
                state <= ST_STOP;
                tx_r  <= 1'b1;
`endif
              end else begin
                bit_idx <= bit_idx + 3'd1;
                tx_r    <= tx_byte[bit_idx + 3'd1];
              end
            end
`ifdef CMD_TX_PARITY_EN
            ST_PARITY: begin
              state <= ST_STOP;
              tx_r  <= 1'b1;
            end
`endif
            ST_STOP: begin
              state   <= ST_IDLE;
              tx_r    <= 1'b1;
              busy_r  <= 1'b0;
              sent_r  <= 1'b1;
              bit_cnt <= 16'd0;
            end
            default: begin
              state   <= ST_IDLE;
              tx_r    <= 1'b1;
              busy_r  <= 1'b0;
              bit_cnt <= 16'd0;
            end
          endcase
        end
      end
    end
  end

  assign bus.TX      = tx_r;
  assign bus.BUSY    = busy_r;
  assign bus.SENT    = sent_r;
  assign bus.PENDING = pend_r;

endmodule

// File: doc/cmd_uart_tx.md
CMD_UART_TX -- requirements
Module: cmd_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, clock cycles per UART bit (50 MHz / 9600 baud), legal range 2..65535.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port MOTOR_STAT  input  3  motor command code (000 idle, 001 fwd, 010 left, 011 brake, 100 right, 101 back, 110/111 invalid).
REQ-005 SHALL have port TX  output  1  UART serial line, idle high.
REQ-006 SHALL have port BUSY  output  1  high while a frame is on TX.
REQ-007 SHALL have port SENT  output  1  one-cycle pulse on frame completion.
REQ-008 SHALL have port PENDING  output  1  high while a code waits for transmission behind the current frame.

Function
REQ-009 SHALL encode codes as 001->0x61, 010->0x62, 011->0x63, 100->0x64, 101->0x65.
REQ-010 SHALL register MOTOR_STAT every cycle (stat_q) and hold last_code, the last code accepted.
REQ-011 SHALL treat stat_q != last_code with stat_q in 001..101 as a new command; last_code <= stat_q.
REQ-012 SHALL treat stat_q == 000 as accepted (last_code <= 000) without transmitting, so a later repeat of the previous command is re-sent.
REQ-013 SHALL ignore 110/111 entirely: no transmission, last_code unchanged.
REQ-014 SHALL use FSM states IDLE, START, DATA, STOP (plus PARITY per REQ-025); IDLE->START on new command or pending; START->DATA, DATA->STOP after bit 7 (or ->PARITY), STOP->IDLE.
REQ-015 SHALL hold each state/bit for exactly CLKS_PER_BIT cycles using a 16-bit bit-period counter reloaded on every bit boundary.
REQ-016 SHALL drive TX low for start, then data bits LSB first, then high for one stop bit; frame = 10*CLKS_PER_BIT cycles.
REQ-017 SHALL drive TX low in the cycle after the edge at which the new command is registered into stat_q's comparison (2 edges after MOTOR_STAT changes).
REQ-018 SHALL assert BUSY in every cycle TX carries start, data, parity or stop; BUSY low in IDLE.
REQ-019 SHALL pulse SENT for exactly one cycle, the first cycle after the stop bit, coincident with BUSY low.
REQ-020 SHALL, on a new command while BUSY, store it in a single-entry pending register and set PENDING; a later new command overwrites it (newest wins).
REQ-021 SHALL, when the frame ends with PENDING set, enter START directly from STOP (no IDLE cycle), clear PENDING, so BUSY stays high between frames and SENT still pulses once.
REQ-022 SHALL, if stat_q returns to 000 while a code is pending, discard the pending code and clear PENDING.

Reset
REQ-023 SHALL on RESET, regardless of state, set FSM=IDLE, TX=1, BUSY=0, SENT=0, PENDING=0, last_code=000, stat_q=000, counters=0; a frame in progress is truncated with TX high the cycle after reset.
REQ-024 SHALL not transmit until the first new command after RESET deasserts.

Configuration
REQ-025 SHALL, with macro CMD_TX_PARITY_EN defined, insert one even-parity bit after bit 7 (PARITY state, CLKS_PER_BIT cycles), frame = 11*CLKS_PER_BIT; without it, no PARITY state, frame = 10*CLKS_PER_BIT.

Verification
REQ-026 SHALL cover: CLKS_PER_BIT=4, MOTOR_STAT 000->001 -> TX 0,1,0,0,0,0,1,1,0,1 (4 cycles each, 0x61), BUSY 40 cycles, one SENT pulse.
REQ-027 SHALL cover: 001 held 200 cycles -> exactly one frame; then 000 then 001 -> second 0x61 frame.
REQ-028 SHALL cover: 010 then 100 then 101 during 010 frame -> PENDING=1, 0x62 then 0x65 back-to-back, BUSY continuous 80 cycles, 0x64 never sent.
REQ-029 SHALL cover: MOTOR_STAT=111 from idle -> TX stays 1, BUSY 0 for 100 cycles.
REQ-030 SHALL cover: RESET at cycle 15 of 0x63 frame -> TX=1, BUSY=0 next cycle, no SENT, no retransmit until code change.
REQ-031 SHALL cover: CMD_TX_PARITY_EN defined, 011 -> 0x63 with parity bit 0 (four ones), 44-cycle frame.
